// File: rtl/branch_condition_predictor.sv
// Branch condition resolution plus a PC-indexed table of saturating counters.
// The ID stage resolves the branch condition and trains the table. The IF stage
// reads a prediction combinationally from the same table. Two saturating
// statistics counters track resolved branches and mispredicts.
module branch_condition_predictor #(
  parameter int ISA_WIDTH       = 32,
  parameter int COND_TYPE_WIDTH = 3,
  parameter int BHT_DEPTH       = 64,
  parameter int CNT_WIDTH       = 2,
  parameter int STAT_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ISA_WIDTH-1:0]       if_pc,
  output logic                       if_predict_taken,
  input  logic                       id_valid,
  input  logic                       id_stall,
  input  logic [ISA_WIDTH-1:0]       id_pc,
  input  logic [COND_TYPE_WIDTH-1:0] condition_type,
  input  logic [ISA_WIDTH-1:0]       read_data_1,
  input  logic [ISA_WIDTH-1:0]       read_data_2,
  input  logic                       id_predicted_taken,
  output logic                       condition_satisfied,
  output logic                       mispredict,
  output logic [STAT_WIDTH-1:0]      branch_count,
  output logic [STAT_WIDTH-1:0]      mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [COND_TYPE_WIDTH-1:0] COND_NONE = COND_TYPE_WIDTH'(0);
  localparam logic [COND_TYPE_WIDTH-1:0] COND_BEQ  = COND_TYPE_WIDTH'(1);
  localparam logic [COND_TYPE_WIDTH-1:0] COND_BNQ  = COND_TYPE_WIDTH'(2);
  localparam logic [COND_TYPE_WIDTH-1:0] COND_BLT  = COND_TYPE_WIDTH'(3);
  localparam logic [COND_TYPE_WIDTH-1:0] COND_BGE  = COND_TYPE_WIDTH'(4);
  localparam logic [COND_TYPE_WIDTH-1:0] COND_BLTU = COND_TYPE_WIDTH'(5);
  localparam logic [COND_TYPE_WIDTH-1:0] COND_BGEU = COND_TYPE_WIDTH'(6);
  localparam logic [COND_TYPE_WIDTH-1:0] COND_BLEZ = COND_TYPE_WIDTH'(7);

  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CNT_WIDTH-1:0]  CNT_INIT  = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX  = {STAT_WIDTH{1'b1}};
  localparam logic [STAT_WIDTH-1:0] STAT_ZERO = {STAT_WIDTH{1'b0}};
  localparam logic [STAT_WIDTH-1:0] STAT_ONE  = STAT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]  r_bht [BHT_DEPTH];
  logic [STAT_WIDTH-1:0] r_branch_count;
  logic [STAT_WIDTH-1:0] r_mispredict_count;

  logic [IDX_W-1:0]      w_if_idx;
  logic [IDX_W-1:0]      w_id_idx;
  logic                  w_cond_sat;
  logic                  w_resolve;
  logic                  w_mispredict;
  logic [CNT_WIDTH-1:0]  w_cnt_cur;
  logic [CNT_WIDTH-1:0]  w_cnt_next;
  logic                  w_unused_pc_bits;

  // Word-aligned PCs: drop the byte offset, keep log2(depth) bits.
  assign w_if_idx = if_pc[2 +: IDX_W];
  assign w_id_idx = id_pc[2 +: IDX_W];

  // Only the index bits of the PCs select an entry; the rest alias.
  assign w_unused_pc_bits = ^{if_pc, id_pc};

  // Evaluate the branch condition for the ID instruction.
  always_comb begin
    w_cond_sat = 1'b0;
    case (condition_type)
      COND_BEQ:  w_cond_sat = (read_data_1 == read_data_2);
      COND_BNQ:  w_cond_sat = (read_data_1 != read_data_2);
      COND_BLT:  w_cond_sat = ($signed(read_data_1) <  $signed(read_data_2));
      COND_BGE:  w_cond_sat = ($signed(read_data_1) >= $signed(read_data_2));
      COND_BLTU: w_cond_sat = (read_data_1 <  read_data_2);
      COND_BGEU: w_cond_sat = (read_data_1 >= read_data_2);
      COND_BLEZ: w_cond_sat = read_data_1[ISA_WIDTH-1] | (read_data_1 == {ISA_WIDTH{1'b0}});
      default:   w_cond_sat = 1'b0;
    endcase
  end

  assign w_resolve    = id_valid & ~id_stall & (condition_type != COND_NONE);
  assign w_mispredict = w_resolve & (w_cond_sat ^ id_predicted_taken);

  assign condition_satisfied = w_cond_sat;
  assign mispredict          = w_mispredict;
  assign if_predict_taken    = r_bht[w_if_idx][CNT_WIDTH-1];
  assign branch_count        = r_branch_count;
  assign mispredict_count    = r_mispredict_count;

  // Saturating step of the counter addressed by the ID instruction.
  always_comb begin
    w_cnt_cur  = r_bht[w_id_idx];
    w_cnt_next = w_cnt_cur;
    if (w_cond_sat) begin
      if (w_cnt_cur != CNT_MAX) begin
        w_cnt_next = w_cnt_cur + CNT_ONE;
      end else begin
        w_cnt_next = w_cnt_cur;
      end
    end else begin
      if (w_cnt_cur != CNT_ZERO) begin
        w_cnt_next = w_cnt_cur - CNT_ONE;
      end else begin
        w_cnt_next = w_cnt_cur;
      end
    end
  end

  // Prediction table: reset to weakly not-taken, trained on resolve events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= CNT_INIT;
      end
    end else if (w_resolve) begin
      r_bht[w_id_idx] <= w_cnt_next;
    end
  end

  // Saturating statistics of resolved branches and mispredicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_count     <= STAT_ZERO;
      r_mispredict_count <= STAT_ZERO;
    end else begin
      if (w_resolve && (r_branch_count != STAT_MAX)) begin
        r_branch_count <= r_branch_count + STAT_ONE;
      end
      if (w_mispredict && (r_mispredict_count != STAT_MAX)) begin
        r_mispredict_count <= r_mispredict_count + STAT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_condition_predictor.sv
// Randomised + directed bench for branch_condition_predictor. Two instances share
// stimulus: one with default parameters, one small (8 entries, 3-bit counters,
// 4-bit statistics) to reach saturation. A behavioural model predicts outputs.
module tb_branch_condition_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        id_valid;
  logic        id_stall;
  logic [31:0] id_pc;
  logic [2:0]  condition_type;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic        id_predicted_taken;

  logic        pred0, cond0, misp0;
  logic [15:0] bc0, mc0;
  logic        pred1, cond1, misp1;
  logic [3:0]  bc1, mc1;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_bht0 [64];
  int m_bht1 [8];
  int m_bc0, m_mc0, m_bc1, m_mc1;

  branch_condition_predictor dut0 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_predict_taken(pred0),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
    .condition_type(condition_type), .read_data_1(read_data_1),
    .read_data_2(read_data_2), .id_predicted_taken(id_predicted_taken),
    .condition_satisfied(cond0), .mispredict(misp0),
    .branch_count(bc0), .mispredict_count(mc0)
  );

  branch_condition_predictor #(
    .ISA_WIDTH(32), .COND_TYPE_WIDTH(3), .BHT_DEPTH(8), .CNT_WIDTH(3), .STAT_WIDTH(4)
  ) dut1 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_predict_taken(pred1),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
    .condition_type(condition_type), .read_data_1(read_data_1),
    .read_data_2(read_data_2), .id_predicted_taken(id_predicted_taken),
    .condition_satisfied(cond1), .mispredict(misp1),
    .branch_count(bc1), .mispredict_count(mc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Branch outcome from the ISA definition using wide integer arithmetic.
  function automatic bit m_cond(input int ct, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (ct)
      1: return ua == ub;
      2: return ua != ub;
      3: return sa < sb;
      4: return sa >= sb;
      5: return ua < ub;
      6: return ua >= ub;
      7: return sa <= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_resolve();
    return id_valid && !id_stall && (condition_type != 3'd0);
  endfunction

  task automatic m_reset();
    foreach (m_bht0[i]) m_bht0[i] = 1;
    foreach (m_bht1[i]) m_bht1[i] = 3;
    m_bc0 = 0; m_mc0 = 0; m_bc1 = 0; m_mc1 = 0;
  endtask

  task automatic m_update();
    bit t, mp;
    int i0, i1;
    if (m_resolve()) begin
      t  = m_cond(int'(condition_type), read_data_1, read_data_2);
      mp = (t != id_predicted_taken);
      i0 = int'((id_pc / 4) % 64);
      i1 = int'((id_pc / 4) % 8);
      if (t) begin
        m_bht0[i0] = (m_bht0[i0] < 3) ? m_bht0[i0] + 1 : 3;
        m_bht1[i1] = (m_bht1[i1] < 7) ? m_bht1[i1] + 1 : 7;
      end else begin
        m_bht0[i0] = (m_bht0[i0] > 0) ? m_bht0[i0] - 1 : 0;
        m_bht1[i1] = (m_bht1[i1] > 0) ? m_bht1[i1] - 1 : 0;
      end
      m_bc0 = (m_bc0 < 65535) ? m_bc0 + 1 : 65535;
      m_bc1 = (m_bc1 < 15) ? m_bc1 + 1 : 15;
      if (mp) begin
        m_mc0 = (m_mc0 < 65535) ? m_mc0 + 1 : 65535;
        m_mc1 = (m_mc1 < 15) ? m_mc1 + 1 : 15;
      end
    end
  endtask

  // Compare every observable output of both instances against the model.
  task automatic check_all();
    bit ec, em;
    ec = m_cond(int'(condition_type), read_data_1, read_data_2);
    em = m_resolve() && (ec != id_predicted_taken);
    chk("cond0", cond0, ec);
    chk("misp0", misp0, em);
    chk("pred0", pred0, (m_bht0[int'((if_pc / 4) % 64)] >= 2));
    chk("bc0",   bc0, m_bc0);
    chk("mc0",   mc0, m_mc0);
    chk("cond1", cond1, ec);
    chk("misp1", misp1, em);
    chk("pred1", pred1, (m_bht1[int'((if_pc / 4) % 8)] >= 4));
    chk("bc1",   bc1, m_bc1);
    chk("mc1",   mc1, m_mc1);
  endtask

  // One clock: check at the falling edge, update the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!rst) m_update();
    #1;
  endtask

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [7:0] sweep_exp;
    sweep_exp = 8'hCC;

    // Reset state
    rst = 1'b1; if_pc = 32'h40; id_valid = 1'b0; id_stall = 1'b0; id_pc = 32'h0;
    condition_type = 3'd0; read_data_1 = 32'h0; read_data_2 = 32'h0;
    id_predicted_taken = 1'b0;
    m_reset();
    cycle();
    chk("rst_pred", pred0, 0);
    chk("rst_bc", bc0, 0);
    chk("rst_mc", mc0, 0);
    cycle();
    rst = 1'b0;

    // Condition sweep with -1 vs 1
    read_data_1 = 32'hFFFF_FFFF; read_data_2 = 32'h0000_0001;
    for (int c = 0; c < 8; c++) begin
      condition_type = 3'(c);
      #1;
      chk($sformatf("sweep_%0d", c), cond0, sweep_exp[c]);
      cycle();
    end

    // Training at 0x40 (index 16)
    id_valid = 1'b1; id_stall = 1'b0; id_pc = 32'h40; if_pc = 32'h40;
    condition_type = 3'd1; read_data_1 = 32'h5; read_data_2 = 32'h5;
    id_predicted_taken = 1'b0;
    #1;
    chk("train_misp1", misp0, 1);
    chk("train_pred0", pred0, 0);
    cycle();
    chk("train_pred_e1", pred0, 1);
    chk("train_misp2", misp0, 1);
    cycle();
    chk("train_misp3", misp0, 1);
    cycle();
    chk("model_cnt_sat", m_bht0[16], 3);
    chk("train_bc", bc0, 3);
    chk("train_mc", mc0, 3);

    // Stalled not-taken at alias 0x140 changes nothing
    id_pc = 32'h140; read_data_2 = 32'h6; id_stall = 1'b1;
    #1;
    chk("stall_misp", misp0, 0);
    cycle();
    chk("stall_pred", pred0, 1);
    chk("stall_bc", bc0, 3);
    // Unstalled: two not-taken at 0x140 walk the shared entry 3 -> 1
    id_stall = 1'b0;
    cycle();
    cycle();
    chk("alias_pred", pred0, 0);
    chk("alias_bc", bc0, 5);
    chk("alias_mc", mc0, 3);

    // Statistics saturation on the 4-bit instance
    id_pc = 32'h200; read_data_2 = 32'h5;
    repeat (20) cycle();
    chk("sat_bc1", bc1, 15);
    chk("sat_bc0", bc0, 25);

    // Same-cycle read/write at 0x80 from the reset state
    rst = 1'b1; m_reset();
    cycle();
    rst = 1'b0;
    if_pc = 32'h80; id_pc = 32'h80;
    #1;
    chk("same_old", pred0, 0);
    cycle();
    chk("same_new", pred0, 1);

    // Asynchronous reset with no clock edge
    rst = 1'b1; m_reset();
    #1;
    chk("async_rst", pred0, 0);
    cycle();
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst                = ($urandom_range(0, 199) == 0);
      if_pc              = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
      id_pc              = ($urandom_range(0, 3) == 0) ? if_pc
                           : (($urandom_range(0, 127) << 2) | $urandom_range(0, 3));
      id_valid           = ($urandom_range(0, 9) != 0);
      id_stall           = ($urandom_range(0, 4) == 0);
      condition_type     = 3'($urandom_range(0, 7));
      read_data_1        = pick_data();
      read_data_2        = ($urandom_range(0, 4) == 0) ? read_data_1 : pick_data();
      id_predicted_taken = 1'($urandom_range(0, 1));
      if (rst) m_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
